// File: rtl/smpl_hit_tally_pkg.sv
// Shared types for the per-triangle hit tally: record layout, triangle state, lane popcount.
package smpl_tally_pkg;

  localparam int unsigned DEF_TAG_W = 16;
  localparam int unsigned DEF_CNT_W = 24;
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned LCNT_W    = 5;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_CNT_W-1:0] hits;
    logic [DEF_CNT_W-1:0] samps;
    logic                 sat;
  } tally_rec_t;

  typedef enum logic {TRI_IDLE, TRI_OPEN} tri_state_e;

  function automatic logic [LCNT_W-1:0] popcount_lanes(input logic [MAX_LANES-1:0] v);
    logic [LCNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) n = n + LCNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/smpl_hit_tally_if.sv
// Record drain port of the hit tally: valid/ready plus the record fields.
interface smpl_hit_tally_if #(
  parameter int unsigned TAG_W = 16,
  parameter int unsigned CNT_W = 24
);
  logic             rec_valid;
  logic             rec_ready;
  logic [TAG_W-1:0] rec_tag;
  logic [CNT_W-1:0] rec_hits;
  logic [CNT_W-1:0] rec_samps;
  logic             rec_sat;

  modport master (output rec_valid, rec_tag, rec_hits, rec_samps, rec_sat, input rec_ready);
  modport slave  (input rec_valid, rec_tag, rec_hits, rec_samps, rec_sat, output rec_ready);
endinterface

// File: rtl/smpl_hit_tally_fifo.sv
// Synchronous record FIFO; head is read straight from the registered array and zeroed when empty.
module tally_fifo
  import smpl_tally_pkg::*;
#(
  parameter type         T     = tally_rec_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_wr;
  logic        w_rd;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = o_empty ? T'('0) : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + (AW+1)'(1);
      if (w_rd) r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/smpl_hit_tally.sv
// Per-triangle hit/sample tally with saturating counters, record FIFO and drop accounting.
// Option: SMPL_TALLY_ZERO_FILTER_EN suppresses records whose hit count is zero.
module smpl_hit_tally
  import smpl_tally_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned TAG_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tri_new,
  input  logic [TAG_W-1:0]  tri_tag,
  input  logic              flush,
  input  logic [LANES-1:0]  samp_valid,
  input  logic [LANES-1:0]  hit_valid,
  smpl_hit_tally_if.master  rec,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);
  localparam int unsigned SUM_W = (CNT_W + 1 > LCNT_W) ? CNT_W + 1 : LCNT_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] samps;
    logic             sat;
  } rec_t;

  // Returns {saturated, clamped sum}.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [LCNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {1'b1, {CNT_W{1'b1}}};
    return {1'b0, s[CNT_W-1:0]};
  endfunction

  tri_state_e       r_state, w_state_nxt;
  logic [TAG_W-1:0] r_tag, w_tag_nxt;
  logic [CNT_W-1:0] r_hits, w_hits_nxt, r_samps, w_samps_nxt;
  logic             r_sat, w_sat_nxt;
  logic [MAX_LANES-1:0] w_hit_ext, w_samp_ext;
  logic [LCNT_W-1:0]    w_nh, w_ns;
  logic [CNT_W:0]   w_ld_h, w_ld_s, w_acc_h, w_acc_s;
  logic             w_close, w_push, w_pop, w_full, w_empty, w_drop;
  rec_t             w_rec, w_head;

  always_comb begin
    w_hit_ext  = '0;
    w_samp_ext = '0;
    w_hit_ext[LANES-1:0]  = hit_valid & samp_valid;
    w_samp_ext[LANES-1:0] = samp_valid;
  end

  assign w_nh    = popcount_lanes(w_hit_ext);
  assign w_ns    = popcount_lanes(w_samp_ext);
  assign w_ld_h  = sat_add('0, w_nh);
  assign w_ld_s  = sat_add('0, w_ns);
  assign w_acc_h = sat_add(r_hits, w_nh);
  assign w_acc_s = sat_add(r_samps, w_ns);

  always_comb begin
    w_state_nxt = r_state;
    w_tag_nxt   = r_tag;
    w_hits_nxt  = r_hits;
    w_samps_nxt = r_samps;
    w_sat_nxt   = r_sat;
    w_close     = 1'b0;
    w_rec       = '{tag: r_tag, hits: r_hits, samps: r_samps, sat: r_sat};
    unique case (r_state)
      TRI_IDLE: ;
      TRI_OPEN: begin
        w_hits_nxt  = w_acc_h[CNT_W-1:0];
        w_samps_nxt = w_acc_s[CNT_W-1:0];
        w_sat_nxt   = r_sat | w_acc_h[CNT_W] | w_acc_s[CNT_W];
        if (flush) begin
          w_close     = 1'b1;
          w_rec       = '{tag: r_tag, hits: w_hits_nxt, samps: w_samps_nxt, sat: w_sat_nxt};
          w_state_nxt = TRI_IDLE;
          w_hits_nxt  = '0;
          w_samps_nxt = '0;
          w_sat_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
    // tri_new overrides flush: the old triangle closes as-is, current lanes seed the new one.
    if (tri_new) begin
      w_close     = (r_state == TRI_OPEN);
      w_rec       = '{tag: r_tag, hits: r_hits, samps: r_samps, sat: r_sat};
      w_state_nxt = TRI_OPEN;
      w_tag_nxt   = tri_tag;
      w_hits_nxt  = w_ld_h[CNT_W-1:0];
      w_samps_nxt = w_ld_s[CNT_W-1:0];
      w_sat_nxt   = w_ld_h[CNT_W] | w_ld_s[CNT_W];
    end
  end

`ifdef SMPL_TALLY_ZERO_FILTER_EN
  assign w_push = w_close && (w_rec.hits != '0);
`else
  assign w_push = w_close;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TRI_IDLE;
      r_tag   <= '0;
      r_hits  <= '0;
      r_samps <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      r_hits  <= w_hits_nxt;
      r_samps <= w_samps_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign w_pop  = !w_empty && rec.rec_ready;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (w_drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      overflow <= 1'b1;
    end
  end

  tally_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .i_push (w_push),
    .i_data (w_rec),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign rec.rec_valid = !w_empty;
  assign rec.rec_tag   = w_head.tag;
  assign rec.rec_hits  = w_head.hits;
  assign rec.rec_samps = w_head.samps;
  assign rec.rec_sat   = w_head.sat;

endmodule
